// File: rtl/drum_pkg.sv
// drum_pkg: shared FSM state encoding and helper functions for the DRUM approximate divider.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   state_t    : IDLE / NORM / DIV / SHIFT / DONE
//   exp_width  : width of the signed exponent difference, $clog2(N)+2
//   lod_idx    : index of the most significant set bit, 0 for an all-zero input
package drum_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NORM  = 3'd1,
    DIV   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic int exp_width(input int n);
    return $clog2(n) + 2;
  endfunction

  function automatic int lod_idx(input logic [63:0] x);
    int idx;
    idx = 0;
    for (int i = 0; i < 64; i++) begin
      if (x[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/drum_lod_trunc.sv
// drum_lod_trunc: leading-one detect and K-bit mantissa select for one operand.
// Latency: combinational.
// Backpressure: none (pure function of x).
//
// Ports:
//   x     in  W   operand
//   mant  out K   K bits starting at the leading one (or x[K-1:0] when x is short)
//   shift out SW  number of low bits dropped by the truncation
// Build option: DRUM_DIV_UNBIAS_EN forces the mantissa LSB to 1 whenever bits were dropped.
module drum_lod_trunc
  import drum_pkg::*;
#(
  parameter int K  = 6,
  parameter int W  = 16,
  parameter int SW = $clog2(W) + 1
) (
  input  logic [W-1:0]  x,
  output logic [K-1:0]  mant,
  output logic [SW-1:0] shift
);

  int k;
  int sh;

  always_comb begin
    k     = lod_idx(64'(x));
    sh    = 0;
    mant  = x[K-1:0];
    shift = '0;
    if (k > K - 1) begin
      sh    = k - K + 1;
      mant  = K'(x >> sh);
      shift = SW'(sh);
`ifdef DRUM_DIV_UNBIAS_EN
      // Dropped bits average half an LSB; a forced 1 centres the error.
      mant[0] = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/drum_approx_div.sv
// drum_approx_div: sequential DRUM-style approximate unsigned divider, r ~= a / b.
// Latency: 2K+2 cycles accept-to-out_valid (14 at K=6); 2 cycles when b==0.
// Backpressure: one op in flight; in_ready only in IDLE, result held until out_ready.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; a (N bits) dividend, b (M bits) divisor
//   out_valid/out_ready result handshake; r (N bits) quotient, dz divide-by-zero flag
// Build option: DRUM_DIV_UNBIAS_EN (see drum_lod_trunc) centres the truncation error.
module drum_approx_div
  import drum_pkg::*;
#(
  parameter int K = 6,
  parameter int N = 16,
  parameter int M = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [M-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] r,
  output logic         dz
);

  localparam int EW = exp_width(N);
  localparam int PW = $clog2(N) + 1;
  localparam int QW = $clog2(M) + 1;
  localparam int CW = $clog2(2 * K);
  localparam int XW = N + 2 * K;

  state_t state, state_nxt;

  logic [N-1:0]   a_q;
  logic [M-1:0]   b_q;
  logic [K-1:0]   ma, mb, mb_q;
  logic [PW-1:0]  p, p_q;
  logic [QW-1:0]  q, q_q;
  logic [2*K-1:0] quo;       // dividend bits shift out the top, quotient bits shift in
  logic [K-1:0]   rem;       // always < mb, so K bits hold it between iterations
  logic [CW-1:0]  cnt;
  logic [K:0]     trial;     // K+1-bit partial remainder for this iteration
  logic           fits;

  logic signed [EW-1:0] e;
  logic [EW-1:0]        neg;
  logic [XW-1:0]        qe_ext, scaled;
  logic [N-1:0]         r_calc;

  drum_lod_trunc #(.K(K), .W(N), .SW(PW)) u_lod_a (.x(a_q), .mant(ma), .shift(p));
  drum_lod_trunc #(.K(K), .W(M), .SW(QW)) u_lod_b (.x(b_q), .mant(mb), .shift(q));

  assign in_ready = (state == IDLE);

  // Restoring step: subtract only when the divisor fits.
  always_comb begin
    trial = {rem, quo[2*K-1]};
    fits  = (trial >= {1'b0, mb_q});
  end

  // Rescale by e = p - q - K. The extended word leaves room above bit N-1 so
  // any bit that would be lost by a left shift is visible and forces a clamp.
  always_comb begin
    e      = EW'(p_q) - EW'(q_q) - EW'(K);
    neg    = EW'(-e);
    qe_ext = XW'(quo);
    scaled = '0;
    if (!e[EW-1]) begin
      scaled = qe_ext << e[EW-2:0];
    end else if (int'(neg) < 2 * K) begin
      scaled = qe_ext >> neg;
    end
    r_calc = (|scaled[XW-1:N]) ? {N{1'b1}} : scaled[N-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A zero divisor skips the loop but still passes through SHIFT, where the
  // saturated result is written, giving the 2-cycle latency for that case.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = NORM;
      NORM:    state_nxt = (b_q == '0) ? SHIFT : DIV;
      DIV:     if (cnt == CW'(2 * K - 1)) state_nxt = SHIFT;
      SHIFT:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      mb_q      <= '0;
      p_q       <= '0;
      q_q       <= '0;
      quo       <= '0;
      rem       <= '0;
      cnt       <= '0;
      r         <= '0;
      dz        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
          end
        end
        NORM: begin
          quo  <= {ma, {K{1'b0}}};
          rem  <= '0;
          cnt  <= '0;
          mb_q <= mb;
          p_q  <= p;
          q_q  <= q;
          dz   <= (b_q == '0);
        end
        DIV: begin
          quo <= {quo[2*K-2:0], fits};
          rem <= fits ? K'(trial - {1'b0, mb_q}) : trial[K-1:0];
          cnt <= cnt + CW'(1);
        end
        SHIFT: begin
          r         <= dz ? {N{1'b1}} : r_calc;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            dz        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
